// File: rtl/de1_soc_hex_pkg.sv
// Shared definitions for the DE1-SoC HEX display controller.
// Contents: register word offsets, CTRL field positions, the blank
// segment pattern and the active-low nibble-to-segment table (bit order g..a).
package de1_soc_hex_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_RAW_LO = 2'd2;
  localparam logic [1:0] ADDR_RAW_HI = 2'd3;

  // CTRL field positions
  localparam int CTRL_DEC_LSB    = 0;   // decode_en[7:0]
  localparam int CTRL_BLINK_LSB  = 8;   // blink_en[15:8]
  localparam int CTRL_BRIGHT_LSB = 16;  // brightness[19:16]
  localparam int CTRL_ENABLE_BIT = 31;  // global enable

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments g..a for nibbles 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/de1_soc_hex_display_ctrl_hex_seg_decoder.sv
// hex_seg_decoder: combinational nibble to active-low 7-segment pattern.
// Ports:
//   nibble  in  4  value to display
//   seg     out 7  segments g..a, active-low
module hex_seg_decoder
  import de1_soc_hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/de1_soc_hex_display_ctrl.sv
// de1_soc_hex_display_ctrl: Avalon-MM slave driving up to eight active-low
// 7-segment digits. Each digit shows a hex-decoded nibble or a raw pattern,
// with per-digit blink and a shared 4-bit PWM brightness.
// Ports:
//   clk         in   1            system clock
//   reset_n     in   1            asynchronous active-low reset
//   address     in   2            0 DATA, 1 CTRL, 2 RAW_LO, 3 RAW_HI
//   chipselect  in   1            slave select
//   write_n     in   1            active-low write strobe
//   writedata   in   32           write data (full-word writes)
//   readdata    out  32           combinational read data, zero wait states
//   hex_n       out  NUM_DIGITS*7 registered segments, digit d at [7d+6:7d]
//
// Bus handshake: a write is accepted on every clk edge where chipselect=1
// and write_n=0 (no wait states); readdata always reflects the addressed
// register with no side effects, so a read coinciding with a write returns
// the pre-write value.
module de1_soc_hex_display_ctrl
  import de1_soc_hex_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int BLINK_DIV_W = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_DIGITS*7-1:0] hex_n
);

  // Register file: only bits for implemented digits are stored
  logic [4*NUM_DIGITS-1:0]       data_q;
  logic [NUM_DIGITS-1:0]         dec_en_q;
  logic [NUM_DIGITS-1:0]         blink_en_q;
  logic [3:0]                    bright_q;
  logic                          enable_q;
  logic [NUM_DIGITS-1:0][6:0]    raw_q;

  logic [BLINK_DIV_W-1:0]        blink_cnt;
  logic                          blink_phase;
  logic [3:0]                    pwm_cnt;
  logic                          pwm_on;

  logic [NUM_DIGITS-1:0][6:0]    dec_seg;
  logic [NUM_DIGITS-1:0][6:0]    hex_next;
  logic [NUM_DIGITS-1:0][6:0]    hex_q;

  logic [7:0]                    raw_lane [8];
  logic                          wr_en;
  logic                          unused_wdata;

  assign wr_en = chipselect && !write_n;
  // Bits of writedata outside the stored fields are intentionally dropped
  assign unused_wdata = ^writedata;

  // Register writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      dec_en_q   <= '1;
      blink_en_q <= '0;
      bright_q   <= 4'hF;
      enable_q   <= 1'b0;
      raw_q      <= {NUM_DIGITS{SEG_BLANK}};
    end else if (wr_en) begin
      if (address == ADDR_DATA) begin
        data_q <= writedata[4*NUM_DIGITS-1:0];
      end
      if (address == ADDR_CTRL) begin
        dec_en_q   <= writedata[CTRL_DEC_LSB +: NUM_DIGITS];
        blink_en_q <= writedata[CTRL_BLINK_LSB +: NUM_DIGITS];
        bright_q   <= writedata[CTRL_BRIGHT_LSB +: 4];
        enable_q   <= writedata[CTRL_ENABLE_BIT];
      end
      // Digits 0..3 live in RAW_LO, 4..7 in RAW_HI, one byte lane each
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (address == ((d < 4) ? ADDR_RAW_LO : ADDR_RAW_HI)) begin
          raw_q[d] <= writedata[8*(d%4) +: 7];
        end
      end
    end
  end

  // Read-side byte lanes; lanes for missing digits read as zero
  for (genvar g = 0; g < 8; g++) begin : g_lane
    if (g < NUM_DIGITS) begin : g_impl
      assign raw_lane[g] = {1'b0, raw_q[g]};
    end else begin : g_none
      assign raw_lane[g] = 8'h00;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[4*NUM_DIGITS-1:0] = data_q;
      ADDR_CTRL: begin
        readdata[CTRL_DEC_LSB +: NUM_DIGITS]   = dec_en_q;
        readdata[CTRL_BLINK_LSB +: NUM_DIGITS] = blink_en_q;
        readdata[CTRL_BRIGHT_LSB +: 4]         = bright_q;
        readdata[CTRL_ENABLE_BIT]              = enable_q;
      end
      ADDR_RAW_LO: readdata = {raw_lane[3], raw_lane[2], raw_lane[1], raw_lane[0]};
      default:     readdata = {raw_lane[7], raw_lane[6], raw_lane[5], raw_lane[4]};
    endcase
  end

  // Free-running prescalers; never cleared by register writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= 4'd0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      if (&blink_cnt) begin
        blink_phase <= !blink_phase;
      end
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign pwm_on = (pwm_cnt <= bright_q);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_seg_decoder u_dec (
      .nibble (data_q[4*g +: 4]),
      .seg    (dec_seg[g])
    );
  end

  always_comb begin
    hex_next = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (!enable_q || (blink_en_q[d] && blink_phase) || !pwm_on) begin
        hex_next[d] = SEG_BLANK;
      end else if (dec_en_q[d]) begin
        hex_next[d] = dec_seg[d];
      end else begin
        hex_next[d] = raw_q[d];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_q <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      hex_q <= hex_next;
    end
  end

  assign hex_n = hex_q;

endmodule

// File: tb/tb_de1_soc_hex_display_ctrl.sv
// Bench for de1_soc_hex_display_ctrl (NUM_DIGITS=6, BLINK_DIV_W=4).
// Stimulus pushes expected values into exp_q; a negedge monitor pops one
// entry per cycle and compares it with readdata or hex_n.
module tb_de1_soc_hex_display_ctrl;

  localparam int ND = 6;
  localparam int BW = 4;
  localparam int HW = ND * 7;
  localparam int W  = 64;

  localparam int K_READ = 0;
  localparam int K_HEX  = 1;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_CTRL = 2'd1;
  localparam logic [1:0] A_RLO  = 2'd2;
  localparam logic [1:0] A_RHI  = 2'd3;

  // digit5 .. digit0
  localparam logic [HW-1:0] V_ALL1  = {HW{1'b1}};
  localparam logic [HW-1:0] V_DEC   = {7'h08, 7'h12, 7'h46, 7'h30, 7'h0E, 7'h79};
  localparam logic [HW-1:0] V_RAW0  = {7'h08, 7'h12, 7'h46, 7'h30, 7'h0E, 7'h00};
  localparam logic [HW-1:0] V_BLINK = {7'h08, 7'h12, 7'h46, 7'h30, 7'h0E, 7'h7F};

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [HW-1:0] hex_n;

  de1_soc_hex_display_ctrl #(
    .NUM_DIGITS  (ND),
    .BLINK_DIV_W (BW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .hex_n      (hex_n)
  );

  // Clock edges since reset release; both DUT prescalers advance once per edge
  int edges;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int           kind_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;
  int           mon_kind;
  string        mon_name;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_kind = kind_q.pop_front();
      mon_name = name_q.pop_front();
      if (mon_kind == K_READ) mon_act = {32'b0, readdata};
      else                    mon_act = {{(W-HW){1'b0}}, hex_n};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h (t=%0t)", mon_name, mon_act, mon_exp, $time);
      end
    end
  end

  // Driver tasks
  task automatic push(input int kind, input logic [W-1:0] e, input string n);
    exp_q.push_back(e);
    kind_q.push_back(kind);
    name_q.push_back(n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Write while checking that readdata still shows the pre-write value
  task automatic bus_write_old(input logic [1:0] a, input logic [31:0] d,
                               input logic [31:0] old, input string n);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    push(K_READ, {32'b0, old}, n);
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_check(input logic [1:0] a, input logic [31:0] e, input string n);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    push(K_READ, {32'b0, e}, n);
    step();
    chipselect = 1'b0;
  endtask

  task automatic hex_check(input logic [HW-1:0] e, input string n);
    push(K_HEX, {{(W-HW){1'b0}}, e}, n);
    step();
  endtask

  task automatic check_reset_regs(input string tag);
    hex_check(V_ALL1, {tag, "_hex"});
    read_check(A_DATA, 32'h0000_0000, {tag, "_data"});
    read_check(A_CTRL, 32'h000F_003F, {tag, "_ctrl"});
    read_check(A_RLO,  32'h7F7F_7F7F, {tag, "_raw_lo"});
    read_check(A_RHI,  32'h0000_7F7F, {tag, "_raw_hi"});
  endtask

  initial begin
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    reset_n    = 1'b0;

    step();
    hex_check(V_ALL1, "hex_in_reset");
    reset_n = 1'b1;
    check_reset_regs("reset");

    // Decoded display; first sample after the CTRL edge still shows blank
    bus_write(A_DATA, 32'h00A5_C3F1);
    bus_write(A_CTRL, 32'h800F_003F);
    hex_check(V_ALL1, "hex_latency_blank");
    hex_check(V_DEC,  "hex_decoded");
    read_check(A_DATA, 32'h00A5_C3F1, "data_readback");
    read_check(A_CTRL, 32'h800F_003F, "ctrl_readback");

    // Digit 0 raw, all segments lit
    bus_write(A_CTRL, 32'h800F_003E);
    bus_write(A_RLO,  32'h7F7F_7F00);
    step();
    hex_check(V_RAW0, "hex_raw_digit0");
    read_check(A_RLO, 32'h7F7F_7F00, "raw_lo_readback");

    // Blink on digit 0: phase after m edges is (m/16)%2
    bus_write(A_CTRL, 32'h800F_013F);
    step();
    for (int i = 0; i < 40; i++) begin
      if ((((edges - 1) / 16) % 2) == 1) hex_check(V_BLINK, "hex_blink_off");
      else                               hex_check(V_DEC,   "hex_blink_on");
    end

    // Brightness 3: lit only when the previous-edge pwm count is 0..3
    bus_write(A_CTRL, 32'h8003_003F);
    step();
    for (int i = 0; i < 32; i++) begin
      if (((edges - 1) % 16) <= 3) hex_check(V_DEC,  "hex_pwm_on");
      else                         hex_check(V_ALL1, "hex_pwm_off");
    end

    // Unimplemented bits are dropped; read during write returns old value
    bus_write_old(A_CTRL, 32'hFFFF_FFFF, 32'h8003_003F, "ctrl_read_during_write");
    read_check(A_CTRL, 32'h800F_3F3F, "ctrl_undef_bits");
    bus_write(A_DATA, 32'hFFFF_FFFF);
    read_check(A_DATA, 32'h00FF_FFFF, "data_undef_bits");
    bus_write(A_RHI, 32'hFFFF_FFFF);
    read_check(A_RHI, 32'h0000_7F7F, "raw_hi_undef_bits");
    bus_write(A_RLO, 32'hFFFF_FFFF);
    read_check(A_RLO, 32'h7F7F_7F7F, "raw_lo_undef_bits");

    // Lit display, then asynchronous reset with no clock edge before sampling
    bus_write(A_DATA, 32'h00A5_C3F1);
    bus_write(A_CTRL, 32'h800F_003F);
    step();
    hex_check(V_DEC, "hex_before_reset");
    reset_n = 1'b0;
    hex_check(V_ALL1, "hex_async_reset");
    step();
    reset_n = 1'b1;
    check_reset_regs("rereset");

    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      errors += exp_q.size();
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
